box_plotter: RTL
================

BOX_PLOTTER -- requirements
Module: box_plotter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160: visible width in pixels, used for clipping.
REQ-002 SHALL have parameter SCREEN_H, default 120: visible height in pixels, used for clipping.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock (CLOCK_50 domain).
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a clear-then-draw job.
REQ-007 SHALL have port box_x0, input, 8 bits: left column of the erase box.
REQ-008 SHALL have port box_y0, input, 7 bits: top row of the erase box.
REQ-009 SHALL have port box_w, input, 8 bits: erase box width (0 means no clear).
REQ-010 SHALL have port box_h, input, 7 bits: erase box height (0 means no clear).
REQ-011 SHALL have port fg_colour, input, 3 bits: RGB colour for shape pixels.
REQ-012 SHALL have port draw_valid, input, 1 bit: upstream shape drawer presents a pixel.
REQ-013 SHALL have port draw_x, input, 8 bits: shape pixel column.
REQ-014 SHALL have port draw_y, input, 7 bits: shape pixel row.
REQ-015 SHALL have port draw_done, input, 1 bit: shape drawer has finished.
REQ-016 SHALL have port draw_ready, output, 1 bit: block accepts a shape pixel this cycle.
REQ-017 SHALL have port x, output, 8 bits: pixel column to vga_adapter.
REQ-018 SHALL have port y, output, 7 bits: pixel row to vga_adapter.
REQ-019 SHALL have port colour, output, 3 bits: pixel colour to vga_adapter.
REQ-020 SHALL have port plot, output, 1 bit: vga_adapter write enable.
REQ-021 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-022 SHALL have port done, output, 1 bit: one-cycle pulse at job end.

Function
REQ-023 SHALL implement an FSM with states IDLE, CLEAR, DRAW, FINISH.
REQ-024 In IDLE with start=1, SHALL latch box_x0/y0/w/h and fg_colour, then enter CLEAR; if box_w=0 or box_h=0, SHALL go directly to DRAW.
REQ-025 In IDLE, start=0 SHALL hold IDLE; start SHALL be ignored in every other state.
REQ-026 CLEAR SHALL raster-scan one pixel per cycle, x fastest, from (x0,y0) to (x0+w-1, y0+h-1), driving colour=3'b000.
REQ-027 After the last pixel of CLEAR is issued, SHALL enter DRAW on the next cycle; CLEAR SHALL last exactly w*h cycles.
REQ-028 Scan coordinate arithmetic SHALL be 9-bit (x) and 8-bit (y) internally so that x0+w and y0+h do not wrap.
REQ-029 Any pixel with x >= SCREEN_W or y >= SCREEN_H SHALL be clipped: plot=0 for that cycle; the scan SHALL still advance.
REQ-030 In DRAW, draw_ready SHALL be 1; draw_ready SHALL be 0 in all other states.
REQ-031 In DRAW, when draw_valid=1, SHALL register draw_x/draw_y and output them the next cycle with colour=latched fg_colour and plot=1, subject to clipping (1-cycle latency).
REQ-032 In DRAW, draw_done=1 SHALL move to FINISH; a draw_valid pixel in the same cycle SHALL still be plotted.
REQ-033 FINISH SHALL last one cycle with done=1, then return to IDLE.
REQ-034 x, y, colour and plot SHALL be registered outputs; plot SHALL be 0 in IDLE and FINISH, except for the trailing pixel from REQ-032.
REQ-035 draw_valid and draw_done outside DRAW SHALL be ignored.

Reset
REQ-036 Reset SHALL asynchronously force state=IDLE, x=0, y=0, colour=0, plot=0, draw_ready=0, busy=0, done=0, and clear all latched fields.
REQ-037 Reset asserted mid-CLEAR or mid-DRAW SHALL abort the job with no further plot pulses; after release, a new start is required.

Verification
REQ-038 start with box (10,20), w=2, h=2, fg=3'b100 -> plot=1, colour=000 at (10,20), (11,20), (10,21), (11,21) on consecutive cycles, then draw_ready=1.
REQ-039 start with w=0 -> no CLEAR plots; draw_ready=1 on the cycle after start.
REQ-040 box (158,119), w=4, h=2 -> 8 scan cycles; plot=1 only at (158,119) and (159,119).
REQ-041 In DRAW, draw_valid with (79,63) -> one cycle later x=79, y=63, colour=fg, plot=1; draw_done with draw_valid at (80,64) -> (80,64) plotted, then done=1 for 1 cycle, busy=0.
REQ-042 Reset pulse on the 3rd CLEAR cycle of a 4x4 box -> plot=0 immediately and state IDLE; start pulses issued mid-job -> ignored (plot count unchanged).

Source files
------------

// File: rtl/box_plotter.sv
// rtl/box_plotter.sv - clear-then-draw pixel sequencer feeding a vga_adapter
//
// Purpose: on start, erases a rectangle by raster-scanning black pixels into it,
// then forwards pixels from an upstream shape drawer in the latched foreground
// colour until the drawer signals done. Pixels outside the screen are clipped.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - single-cycle job request (sampled only in IDLE)
//   box_x0/box_y0       - top-left corner of the erase box
//   box_w/box_h         - erase box size; a zero in either skips the clear
//   fg_colour           - colour for shape pixels
//   draw_valid/draw_x/draw_y/draw_done - upstream shape drawer pixel stream
//   draw_ready          - high while shape pixels are accepted
//   x, y, colour, plot  - registered pixel write to the vga_adapter
//   busy                - high whenever a job is in progress
//   done                - one-cycle pulse at job end
module box_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] box_x0,
    input  logic [6:0] box_y0,
    input  logic [7:0] box_w,
    input  logic [6:0] box_h,
    input  logic [2:0] fg_colour,
    input  logic       draw_valid,
    input  logic [7:0] draw_x,
    input  logic [6:0] draw_y,
    input  logic       draw_done,
    output logic       draw_ready,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FINISH} state_t;

    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    state_t     state, state_next;

    logic [7:0] lat_x0;
    logic [6:0] lat_y0;
    logic [7:0] lat_w;
    logic [6:0] lat_h;
    logic [2:0] lat_fg;

    // Scan position is kept one bit wider than the screen coordinates so that
    // a box hanging off the right or bottom edge never wraps back on-screen.
    logic [8:0] scan_x, scan_x_next, x_last;
    logic [7:0] scan_y, scan_y_next, y_last;
    logic       box_empty, at_row_end, at_last;

    function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
        return (px < X_LIM) && (py < Y_LIM);
    endfunction

    assign box_empty  = (box_w == 8'd0) || (box_h == 7'd0);
    assign x_last     = {1'b0, lat_x0} + {1'b0, lat_w} - 9'd1;
    assign y_last     = {1'b0, lat_y0} + {1'b0, lat_h} - 8'd1;
    assign at_row_end = (scan_x == x_last);
    assign at_last    = at_row_end && (scan_y == y_last);

    always_comb begin
        scan_x_next = scan_x + 9'd1;
        scan_y_next = scan_y;
        if (at_row_end) begin
            scan_x_next = {1'b0, lat_x0};
            scan_y_next = scan_y + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = box_empty ? DRAW : CLEAR;
            CLEAR:   if (at_last) state_next = DRAW;
            DRAW:    if (draw_done) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    assign draw_ready = (state == DRAW);
    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);

    // The first clear pixel is registered on the start edge, so each CLEAR
    // cycle shows its own pixel and the clear takes exactly w*h cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_x0 <= '0;
            lat_y0 <= '0;
            lat_w  <= '0;
            lat_h  <= '0;
            lat_fg <= '0;
            scan_x <= '0;
            scan_y <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_x0 <= box_x0;
                        lat_y0 <= box_y0;
                        lat_w  <= box_w;
                        lat_h  <= box_h;
                        lat_fg <= fg_colour;
                        scan_x <= {1'b0, box_x0};
                        scan_y <= {1'b0, box_y0};
                        if (!box_empty) begin
                            x      <= box_x0;
                            y      <= box_y0;
                            colour <= 3'b000;
                            plot   <= on_screen({1'b0, box_x0}, {1'b0, box_y0});
                        end
                    end
                end
                CLEAR: begin
                    if (!at_last) begin
                        scan_x <= scan_x_next;
                        scan_y <= scan_y_next;
                        x      <= scan_x_next[7:0];
                        y      <= scan_y_next[6:0];
                        colour <= 3'b000;
                        plot   <= on_screen(scan_x_next, scan_y_next);
                    end
                end
                DRAW: begin
                    if (draw_valid) begin
                        x      <= draw_x;
                        y      <= draw_y;
                        colour <= lat_fg;
                        plot   <= on_screen({1'b0, draw_x}, {1'b0, draw_y});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
